// File: rtl/morse_decoder.sv
// ---------------------------------------------------------------------------
// morse_decoder
//
// Receive side of the Morse link. The serial on/off line (din) is sampled
// once per symbol-rate strobe (tick). Mark and space run lengths are measured
// in ticks and classified into dots and dashes, which are collected into a
// 4-bit pattern. The first element goes in bit 0, and a 1 marks a dash.
// When a letter gap is seen, the (element count, pattern) pair is looked up
// and mapped back to a 3-bit letter code (000=s .. 111=z).
//
// Malformed input (a mark that is neither a dot nor a dash, too many
// elements, or an unknown pattern) raises a one-clk err pulse. Apart from
// the unknown-pattern case, the receiver then waits in RESYNC for a clean
// letter gap before it accepts new marks.
//
// Ports:
//   clk           in   system clock
//   reset_n       in   synchronous active-low reset
//   tick          in   one-clk symbol-rate strobe; din is sampled only when 1
//   din           in   Morse line, 1 = on
//   letter        out  [2:0] last successfully decoded letter code
//   letter_valid  out  one-clk pulse when letter has been updated
//   err           out  one-clk pulse on a malformed or unknown letter
//   busy          out  1 while a letter is being received (state != IDLE)
// ---------------------------------------------------------------------------
module morse_decoder #(
    parameter int DOT_UNITS  = 1,  // mark length of a dot, in ticks
    parameter int DASH_UNITS = 3,  // mark length of a dash, in ticks
    parameter int GAP_UNITS  = 3,  // space ticks that terminate a letter
    parameter int MAX_ELEMS  = 4   // maximum dots+dashes per letter (<= 4)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       din,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       err,
    output logic       busy
);

    // FSM encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MARK   = 2'd1;
    localparam logic [1:0] SPACE  = 2'd2;
    localparam logic [1:0] RESYNC = 2'd3;

    // Parameters narrowed to the width of the counters they are compared with
    localparam logic [2:0] DOT_L  = 3'(DOT_UNITS);
    localparam logic [2:0] DASH_L = 3'(DASH_UNITS);
    localparam logic [2:0] GAP_L  = 3'(GAP_UNITS);
    localparam logic [2:0] MAX_L  = 3'(MAX_ELEMS);

    // Letter codes
    localparam logic [2:0] LTR_S = 3'd0;
    localparam logic [2:0] LTR_T = 3'd1;
    localparam logic [2:0] LTR_U = 3'd2;
    localparam logic [2:0] LTR_V = 3'd3;
    localparam logic [2:0] LTR_W = 3'd4;
    localparam logic [2:0] LTR_X = 3'd5;
    localparam logic [2:0] LTR_Y = 3'd6;
    localparam logic [2:0] LTR_Z = 3'd7;

    typedef struct packed {
        logic       hit;
        logic [2:0] code;
    } lookup_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [1:0] state_q,   state_d;
    logic [2:0] run_q,     run_d;      // mark or space length, in ticks
    logic [2:0] elems_q,   elems_d;    // elements collected so far (0..4)
    logic [3:0] pattern_q, pattern_d;  // element k in bit k, 1 = dash
    logic [2:0] letter_q,  letter_d;
    logic       valid_q,   valid_d;
    logic       err_q,     err_d;

    // -----------------------------------------------------------------------
    // Pattern lookup. Unused upper pattern bits are always 0 because the
    // pattern is cleared whenever a letter starts, ends or is discarded, so
    // the full 4-bit value can be matched directly.
    // -----------------------------------------------------------------------
    function automatic lookup_t lookup(input logic [2:0] cnt, input logic [3:0] pat);
        lookup_t res;
        res.hit  = 1'b1;
        res.code = LTR_S;
        case ({cnt, pat})
            {3'd3, 4'b0000}: res.code = LTR_S;  // ...
            {3'd1, 4'b0001}: res.code = LTR_T;  // -
            {3'd3, 4'b0100}: res.code = LTR_U;  // ..-
            {3'd4, 4'b1000}: res.code = LTR_V;  // ...-
            {3'd3, 4'b0110}: res.code = LTR_W;  // .--
            {3'd4, 4'b1001}: res.code = LTR_X;  // -..-
            {3'd4, 4'b1101}: res.code = LTR_Y;  // -.--
            {3'd4, 4'b0011}: res.code = LTR_Z;  // --..
            default:         res.hit  = 1'b0;
        endcase
        return res;
    endfunction

    // Run counter increment. It saturates at 7 so that a long run can never
    // wrap around and look like a short one.
    logic [2:0] run_inc;
    assign run_inc = (run_q == 3'd7) ? 3'd7 : run_q + 3'd1;

    // Mark classification, evaluated when a mark ends (din falls)
    logic is_dot, is_dash;
    assign is_dot  = (run_q == DOT_L);
    assign is_dash = (run_q == DASH_L);

    lookup_t lk;
    assign lk = lookup(elems_q, pattern_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        elems_d   = elems_q;
        pattern_d = pattern_q;
        letter_d  = letter_q;
        valid_d   = 1'b0;  // pulses last one clk, so they clear every cycle
        err_d     = 1'b0;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (din) begin
                        state_d = MARK;
                        run_d   = 3'd1;
                    end
                end

                MARK: begin
                    if (din) begin
                        if (run_inc > DASH_L) begin
                            // The mark is already too long to be a dash.
                            // This sample is a 1, so the zero count starts at 0.
                            err_d     = 1'b1;
                            state_d   = RESYNC;
                            run_d     = 3'd0;
                            elems_d   = 3'd0;
                            pattern_d = 4'b0000;
                        end else begin
                            run_d = run_inc;
                        end
                    end else if (!(is_dot || is_dash) || (elems_q == MAX_L)) begin
                        // Bad mark length, or one element too many. This
                        // falling sample is already the first space tick.
                        err_d     = 1'b1;
                        state_d   = RESYNC;
                        run_d     = 3'd1;
                        elems_d   = 3'd0;
                        pattern_d = 4'b0000;
                    end else begin
                        pattern_d[elems_q[1:0]] = is_dash;
                        elems_d = elems_q + 3'd1;
                        state_d = SPACE;
                        run_d   = 3'd1;
                    end
                end

                SPACE: begin
                    if (din) begin
                        // Any gap shorter than a letter gap is an
                        // intra-letter gap.
                        state_d = MARK;
                        run_d   = 3'd1;
                    end else if (run_inc == GAP_L) begin
                        if (lk.hit) begin
                            letter_d = lk.code;
                            valid_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d   = IDLE;
                        run_d     = 3'd0;
                        elems_d   = 3'd0;
                        pattern_d = 4'b0000;
                    end else begin
                        run_d = run_inc;
                    end
                end

                RESYNC: begin
                    // Only a clean run of GAP_UNITS zeros gets the decoder
                    // back to IDLE. No further errors are reported here.
                    if (din) begin
                        run_d = 3'd0;
                    end else if (run_inc >= GAP_L) begin
                        state_d = IDLE;
                        run_d   = 3'd0;
                    end else begin
                        run_d = run_inc;
                    end
                end

                default: begin
                    state_d   = IDLE;
                    run_d     = 3'd0;
                    elems_d   = 3'd0;
                    pattern_d = 4'b0000;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers. The reset is synchronous and takes priority over a tick
    // in the same cycle.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every register samples its pre-edge inputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            run_q     <= 3'd0;
            elems_q   <= 3'd0;
            pattern_q <= 4'b0000;
            letter_q  <= LTR_S;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            elems_q   <= elems_d;
            pattern_q <= pattern_d;
            letter_q  <= letter_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign letter       = letter_q;
    assign letter_valid = valid_q;
    assign err          = err_q;
    assign busy         = (state_q != IDLE);

endmodule
